// File: rtl/buffer_rr_drain_pkg.sv
// ----------------------------------------------------------------------------
// buffer_rr_drain_pkg
// Shared definitions for the flow blocks: FSM state encoding, the default
// word emitted when a source reports an error, and a small modular-add
// helper used by the round-robin picker.
// ----------------------------------------------------------------------------
package buffer_rr_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_HALT  = 2'd2
    } flow_state_t;

    localparam logic [31:0] FLOW_ERRORCODE = 32'hDEADBEEF;

    // (base + offset) mod modulus, for small non-negative operands.
    function automatic int wrap_add(input int base, input int offset, input int modulus);
        return (base + offset) % modulus;
    endfunction

endpackage

// File: rtl/buffer_rr_drain_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req starting at ptr and wrapping
// modulo N_SRC; returns the first requesting index.
//
// Ports
//   req    in   N_SRC      request mask
//   ptr    in   LOG_N_SRC  scan start index
//   found  out  1          at least one request bit set
//   idx    out  LOG_N_SRC  first requester at or after ptr (0 when !found)
// ----------------------------------------------------------------------------
module rr_pick
    import buffer_rr_drain_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int LOG_N_SRC = 2
) (
    input  logic [N_SRC-1:0]     req,
    input  logic [LOG_N_SRC-1:0] ptr,
    output logic                 found,
    output logic [LOG_N_SRC-1:0] idx
);

    logic [LOG_N_SRC-1:0] w_cand;

    // Walk the ring from farthest to nearest so the last hit, which is the
    // one closest to ptr, is the one that sticks.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_cand = LOG_N_SRC'(wrap_add(int'(ptr), k, N_SRC));
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/buffer_rr_drain.sv
// ----------------------------------------------------------------------------
// buffer_rr_drain
// Drains N_SRC buffer sources round-robin, up to BURST words per grant,
// one word every two cycles. The registered delete gives the source one
// cycle to advance its head before it is looked at again. Any source error
// emits a single ERRORCODE word and stops the block until reset.
//
// Ports
//   clk         in   1           clock, all logic on posedge
//   reset       in   1           synchronous, active-high
//   in_full     in   N_SRC       per-source head word valid
//   in_data     in   N_SRC*WDTH  per-source head word, source i at [i*WDTH +: WDTH]
//   in_error    in   N_SRC       per-source error
//   out_delete  out  N_SRC       registered pop strobe, one-hot or zero
//   out_data    out  WDTH        drained word or ERRORCODE
//   out_nd      out  1           out_data valid this cycle
//   out_src     out  LOG_N_SRC   source index of out_data
//   halted      out  1           sticky error stop
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | pick next source from ptr; no output
// SERVE  | issue one word from grant, or wait out the delete holdoff
// HALT   | error seen; outputs quiet until reset
// ----------------------------------------------------------------------------
module buffer_rr_drain
    import buffer_rr_drain_pkg::*;
#(
    parameter int              WDTH      = 32,
    parameter int              N_SRC     = 4,
    parameter int              LOG_N_SRC = 2,
    parameter int              BURST     = 4,
    parameter logic [WDTH-1:0] ERRORCODE = WDTH'(FLOW_ERRORCODE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        in_full,
    input  logic [N_SRC*WDTH-1:0]   in_data,
    input  logic [N_SRC-1:0]        in_error,
    output logic [N_SRC-1:0]        out_delete,
    output logic [WDTH-1:0]         out_data,
    output logic                    out_nd,
    output logic [LOG_N_SRC-1:0]    out_src,
    output logic                    halted
);

    localparam int               CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
    localparam logic [LOG_N_SRC-1:0] LAST_SRC = LOG_N_SRC'(N_SRC - 1);

    flow_state_t          r_state;
    logic [LOG_N_SRC-1:0] r_ptr;
    logic [LOG_N_SRC-1:0] r_grant;
    logic [CNT_W-1:0]     r_cnt;
    logic [N_SRC-1:0]     r_out_delete;
    logic [WDTH-1:0]      r_out_data;
    logic                 r_out_nd;
    logic [LOG_N_SRC-1:0] r_out_src;
    logic                 r_halted;

    flow_state_t          w_state_nxt;
    logic [LOG_N_SRC-1:0] w_ptr_nxt;
    logic [LOG_N_SRC-1:0] w_grant_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [N_SRC-1:0]     w_delete_nxt;
    logic [WDTH-1:0]      w_data_nxt;
    logic                 w_nd_nxt;
    logic [LOG_N_SRC-1:0] w_src_nxt;
    logic                 w_halted_nxt;

    logic [N_SRC-1:0]     w_req;
    logic                 w_found;
    logic [LOG_N_SRC-1:0] w_pick;
    logic                 w_any_err;
    logic [LOG_N_SRC-1:0] w_err_idx;
    logic                 w_holdoff;
    logic                 w_grant_full;
    logic [WDTH-1:0]      w_grant_data;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [LOG_N_SRC-1:0] w_ptr_after;

    // A source whose delete is in flight still shows the word just taken,
    // so it is masked out of the pick for that cycle.
    assign w_req = in_full & ~r_out_delete;

    rr_pick #(
        .N_SRC     (N_SRC),
        .LOG_N_SRC (LOG_N_SRC)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    assign w_any_err    = |in_error;
    assign w_holdoff    = r_out_delete[r_grant];
    assign w_grant_full = in_full[r_grant];
    assign w_grant_data = in_data[int'(r_grant) * WDTH +: WDTH];
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_ptr_after  = (r_grant == LAST_SRC) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_err_idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (in_error[k]) begin
                w_err_idx = LOG_N_SRC'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = r_grant;
        w_cnt_nxt    = r_cnt;
        w_delete_nxt = '0;
        w_nd_nxt     = 1'b0;
        w_data_nxt   = r_out_data;
        w_src_nxt    = r_out_src;
        w_halted_nxt = r_halted;

        case (r_state)
            ST_IDLE: begin
                if (w_any_err) begin
                    w_nd_nxt     = 1'b1;
                    w_data_nxt   = ERRORCODE;
                    w_src_nxt    = w_err_idx;
                    w_halted_nxt = 1'b1;
                    w_state_nxt  = ST_HALT;
                end else if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (w_any_err) begin
                    // Error wins over a word that would otherwise issue now.
                    w_nd_nxt     = 1'b1;
                    w_data_nxt   = ERRORCODE;
                    w_src_nxt    = w_err_idx;
                    w_halted_nxt = 1'b1;
                    w_state_nxt  = ST_HALT;
                end else if (w_holdoff) begin
                    // Source is popping the previous word; in_full is stale.
                    w_state_nxt = ST_SERVE;
                end else if (w_grant_full) begin
                    w_delete_nxt[r_grant] = 1'b1;
                    w_nd_nxt              = 1'b1;
                    w_data_nxt            = w_grant_data;
                    w_src_nxt             = r_grant;
                    w_cnt_nxt             = w_cnt_inc;
                    if (w_cnt_inc == BURST_C) begin
                        w_ptr_nxt   = w_ptr_after;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_ptr_nxt   = w_ptr_after;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_HALT: begin
                w_halted_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_out_delete <= '0;
            r_out_data   <= '0;
            r_out_nd     <= 1'b0;
            r_out_src    <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_grant      <= w_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_delete <= w_delete_nxt;
            r_out_data   <= w_data_nxt;
            r_out_nd     <= w_nd_nxt;
            r_out_src    <= w_src_nxt;
            r_halted     <= w_halted_nxt;
        end
    end

    assign out_delete = r_out_delete;
    assign out_data   = r_out_data;
    assign out_nd     = r_out_nd;
    assign out_src    = r_out_src;
    assign halted     = r_halted;

endmodule

// File: tb/tb_buffer_rr_drain.sv
// ----------------------------------------------------------------------------
// tb_buffer_rr_drain
// Source buffers are modelled as FIFOs that pop on out_delete. Whenever words
// are loaded, the expected drain order is computed from the round-robin /
// burst rules and queued; a monitor on the falling edge pops and compares on
// every out_nd and checks the per-cycle delete rules.
// ----------------------------------------------------------------------------
module tb_buffer_rr_drain;

    localparam int WDTH      = 32;
    localparam int N_SRC     = 4;
    localparam int LOG_N_SRC = 2;
    localparam int BURST     = 4;
    localparam int DEPTH     = 256;
    localparam logic [WDTH-1:0] ERRC = 32'hDEADBEEF;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [N_SRC-1:0]       in_full;
    logic [N_SRC*WDTH-1:0]  in_data;
    logic [N_SRC-1:0]       in_error = '0;
    logic [N_SRC-1:0]       out_delete;
    logic [WDTH-1:0]        out_data;
    logic                   out_nd;
    logic [LOG_N_SRC-1:0]   out_src;
    logic                   halted;

    always #5 clk = ~clk;

    buffer_rr_drain #(
        .WDTH      (WDTH),
        .N_SRC     (N_SRC),
        .LOG_N_SRC (LOG_N_SRC),
        .BURST     (BURST),
        .ERRORCODE (ERRC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_full    (in_full),
        .in_data    (in_data),
        .in_error   (in_error),
        .out_delete (out_delete),
        .out_data   (out_data),
        .out_nd     (out_nd),
        .out_src    (out_src),
        .halted     (halted)
    );

    // ---------------- source buffers ----------------
    logic [WDTH-1:0] mem [N_SRC][DEPTH];
    int              head [N_SRC] = '{default: 0};
    int              tail [N_SRC] = '{default: 0};
    logic            flush = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (flush) head[i] <= tail[i];
            else if (out_delete[i] && head[i] != tail[i]) head[i] <= head[i] + 1;
        end
    end

    always_comb begin
        in_full = '0;
        in_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            in_full[i] = (head[i] != tail[i]);
            in_data[i*WDTH +: WDTH] = mem[i][head[i] % DEPTH];
        end
    end

    // ---------------- scoreboard ----------------
    logic [WDTH-1:0] exp_data [$];
    int              exp_src  [$];
    bit              exp_err  [$];
    int              nd_cyc   [$];
    int              model_ptr = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    logic [N_SRC-1:0] prev_del = '0;
    logic             prev_nd  = 1'b0;

    always @(negedge clk) begin : monitor
        logic [N_SRC-1:0] oh;
        cyc++;
        oh = N_SRC'(1) << out_src;
        chk($onehot0(out_delete), "delete_onehot0", 32'(out_delete), 32'(0));
        chk((out_delete & prev_del) == '0, "delete_repeat_same_src", 32'(out_delete), 32'(0));
        if (out_nd && !halted) begin
            chk(out_delete == oh, "delete_matches_nd", 32'(out_delete), 32'(oh));
            chk(!prev_nd, "nd_spacing", 32'(prev_nd), 32'(0));
        end
        if (!out_nd) chk(out_delete == '0, "delete_without_nd", 32'(out_delete), 32'(0));
        if (halted)  chk(out_delete == '0, "delete_while_halted", 32'(out_delete), 32'(0));
        for (int i = 0; i < N_SRC; i++) begin
            if (out_delete[i]) chk(head[i] != tail[i], "delete_of_empty_src", 32'(i), 32'(0));
        end
        if (out_nd) begin
            nd_cyc.push_back(cyc);
            chk(exp_data.size() != 0, "unexpected_nd", out_data, 32'(0));
            if (exp_data.size() != 0) begin
                chk(out_data == exp_data[0], "out_data", out_data, exp_data[0]);
                chk(32'(out_src) == 32'(exp_src[0]), "out_src", 32'(out_src), 32'(exp_src[0]));
                if (exp_err[0]) begin
                    chk(halted == 1'b1, "err_halted", 32'(halted), 32'(1));
                    chk(out_delete == '0, "err_no_delete", 32'(out_delete), 32'(0));
                end
                void'(exp_data.pop_front());
                void'(exp_src.pop_front());
                void'(exp_err.pop_front());
            end
        end
        prev_del = out_delete;
        prev_nd  = out_nd;
    end

    // ---------------- reference model ----------------
    // Round robin over whole buffer contents: from ptr find the first
    // non-empty source, take up to BURST words, move ptr past it, repeat.
    task automatic build_expected();
        int cnt [N_SRC];
        int pos [N_SRC];
        int p, g, take;
        bit more;
        for (int i = 0; i < N_SRC; i++) begin
            cnt[i] = tail[i] - head[i];
            pos[i] = head[i];
        end
        p = model_ptr;
        more = 1'b1;
        while (more) begin
            g = -1;
            for (int k = N_SRC - 1; k >= 0; k--)
                if (cnt[(p + k) % N_SRC] > 0) g = (p + k) % N_SRC;
            if (g < 0) begin
                more = 1'b0;
            end else begin
                take = (cnt[g] < BURST) ? cnt[g] : BURST;
                for (int j = 0; j < take; j++) begin
                    exp_data.push_back(mem[g][pos[g] % DEPTH]);
                    exp_src.push_back(g);
                    exp_err.push_back(1'b0);
                    pos[g]++;
                end
                cnt[g] -= take;
                p = (g + 1) % N_SRC;
            end
        end
        model_ptr = p;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            mem[src][tail[src] % DEPTH] = $urandom;
            tail[src] = tail[src] + 1;
        end
    endtask

    task automatic flush_expected();
        exp_data.delete();
        exp_src.delete();
        exp_err.delete();
    endtask

    task automatic check_zero(input string tag);
        chk(out_nd == 1'b0,    {tag, "_nd"},     32'(out_nd),     32'(0));
        chk(out_delete == '0,  {tag, "_delete"}, 32'(out_delete), 32'(0));
        chk(out_data == '0,    {tag, "_data"},   out_data,        32'(0));
        chk(out_src == '0,     {tag, "_src"},    32'(out_src),    32'(0));
        chk(halted == 1'b0,    {tag, "_halted"}, 32'(halted),     32'(0));
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_data.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        chk(exp_data.size() == 0, "drain_timeout", 32'(exp_data.size()), 32'(0));
        repeat (4) tick();
    endtask

    task automatic do_reset(input bit clear_bufs);
        reset    = 1'b1;
        in_error = '0;
        flush    = clear_bufs;
        flush_expected();
        tick();
        flush = 1'b0;
        tick();
        check_zero("reset");
        reset     = 1'b0;
        model_ptr = 0;
    endtask

    task automatic raise_error(input logic [N_SRC-1:0] e);
        int lowest = 0;
        for (int k = N_SRC - 1; k >= 0; k--) if (e[k]) lowest = k;
        in_error = e;
        flush_expected();
        exp_data.push_back(ERRC);
        exp_src.push_back(lowest);
        exp_err.push_back(1'b1);
        tick();
        chk(exp_data.size() == 0, "err_word_seen", 32'(exp_data.size()), 32'(0));
        for (int k = 0; k < 8; k++) begin
            in_error = N_SRC'($urandom);
            tick();
            chk(halted == 1'b1, "halted_sticky", 32'(halted), 32'(1));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        int gaps [5] = '{2, 2, 2, 3, 2};
        int budget;
        int h0;
        int target;

        repeat (3) tick();
        check_zero("por");
        reset = 1'b0;

        // One source deeper than a burst: four words, re-grant, two words.
        nd_cyc.delete();
        load(1, 6);
        build_expected();
        wait_drain(200);
        chk(nd_cyc.size() == 6, "burst_word_count", 32'(nd_cyc.size()), 32'(6));
        if (nd_cyc.size() == 6)
            for (int k = 0; k < 5; k++)
                chk(nd_cyc[k+1] - nd_cyc[k] == gaps[k], "burst_gap",
                    32'(nd_cyc[k+1] - nd_cyc[k]), 32'(gaps[k]));

        // All sources two words each, starting from ptr 0.
        do_reset(1'b1);
        for (int s = 0; s < N_SRC; s++) load(s, 2);
        build_expected();
        wait_drain(200);

        // Move ptr to 3, then src2 and src3 both full: src3 first.
        load(2, 1);
        build_expected();
        wait_drain(100);
        load(2, 3);
        load(3, 3);
        build_expected();
        wait_drain(200);

        // Random fills.
        for (int it = 0; it < 12; it++) begin
            for (int s = 0; s < N_SRC; s++)
                if ($urandom_range(0, 9) < 6) load(s, $urandom_range(0, 7));
            build_expected();
            wait_drain(400);
        end

        // Reset while a delete is on the wire, then drain the remainder.
        for (int it = 0; it < 4; it++) begin
            for (int s = 0; s < N_SRC; s++) load(s, $urandom_range(2, 7));
            build_expected();
            nd_cyc.delete();
            target = $urandom_range(1, 5);
            budget = 0;
            while (!(nd_cyc.size() >= target && out_delete != '0) && budget < 200) begin
                tick();
                budget++;
            end
            chk(budget < 200, "mid_drain_wait", 32'(budget), 32'(200));
            reset = 1'b1;
            flush_expected();
            tick();
            check_zero("mid_reset");
            reset     = 1'b0;
            model_ptr = 0;
            build_expected();
            wait_drain(400);
        end

        // Error on src2 while src0 is being served.
        do_reset(1'b1);
        load(0, 5);
        load(1, 2);
        build_expected();
        h0 = head[0];
        budget = 0;
        while (head[0] == h0 && budget < 40) begin
            tick();
            budget++;
        end
        chk(head[0] != h0, "src0_first_delete", 32'(head[0]), 32'(h0 + 1));
        raise_error(4'b0100);
        do_reset(1'b1);

        // Random errors at random points, including while idle.
        for (int it = 0; it < 5; it++) begin
            for (int s = 0; s < N_SRC; s++)
                if ($urandom_range(0, 1) == 1) load(s, $urandom_range(1, 6));
            build_expected();
            repeat ($urandom_range(0, 15)) tick();
            raise_error(N_SRC'($urandom_range(1, (1 << N_SRC) - 1)));
            do_reset(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no end required end");
        $fatal(1, "time limit");
    end

endmodule
